// File: rtl/sr_iter_pkg.sv
// -----------------------------------------------------------------------------
// sr_iter_pkg
//   Shared types and helpers for the iterative right shifter (sr_iter).
//   - state_t      : FSM states of the shifter
//   - shw_f        : shift-amount width for a given data width
//   - clamp_shamt  : limits a shift amount to w-1 for non-power-of-2 widths
// -----------------------------------------------------------------------------
package sr_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a shift amount able to address every bit of a w-bit word.
  function automatic int shw_f(input int w);
    if (w > 1) begin
      return $clog2(w);
    end else begin
      return 1;
    end
  endfunction

  // Amounts of w or more only exist when w is not a power of two; they are
  // limited to w-1 so the counter never runs past the word.
  function automatic logic [31:0] clamp_shamt(input logic [31:0] s, input int w);
    if (s >= 32'(w)) begin
      return 32'(w - 1);
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/sr_iter_sr1.sv
// -----------------------------------------------------------------------------
// sr1
//   Combinational one-bit right shift cell.
//   Ports:
//     val_i  in  n  value to shift
//     fill_i in  1  bit entering at the MSB
//     val_o  out n  {fill_i, val_i[n-1:1]}
//     out_o  out 1  bit leaving at the LSB (val_i[0])
// -----------------------------------------------------------------------------
module sr1 #(
  parameter int n = 32
) (
  input  logic [n-1:0] val_i,
  input  logic         fill_i,
  output logic [n-1:0] val_o,
  output logic         out_o
);

  assign val_o = {fill_i, val_i[n-1:1]};
  assign out_o = val_i[0];

endmodule

// File: rtl/sr_iter.sv
// -----------------------------------------------------------------------------
// sr_iter
//   Multi-cycle right shifter: shifts num right by shamt, one bit per clock,
//   with logical (zero) or arithmetic (sign) fill, and reports whether any
//   set bit was shifted out.
//   Ports:
//     clk      in   1    rising-edge clock
//     reset_n  in   1    synchronous active-low reset
//     start    in   1    request, accepted when not busy
//     num      in   n    operand, latched on accept
//     shamt    in   SHW  shift amount, latched on accept
//     arith    in   1    1 = sign fill, 0 = zero fill, latched on accept
//     busy     out  1    high while shifting
//     done     out  1    one-cycle pulse, result/lost valid
//     result   out  n    shifted value, held between operations
//     lost     out  1    OR of every bit shifted out of bit 0
// -----------------------------------------------------------------------------
module sr_iter
  import sr_iter_pkg::*;
#(
  parameter int n   = 32,
  parameter int SHW = shw_f(n)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [n-1:0]   num,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
  output logic           busy,
  output logic           done,
  output logic [n-1:0]   result,
  output logic           lost
);

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);

  state_t         state_q;
  logic [n-1:0]   data_q;
  logic [SHW-1:0] cnt_q;
  logic           fill_q;      // already resolved: sign bit when arith, else 0
  logic           lost_acc_q;  // accumulates during SHIFT; published in DONE
  logic           busy_q;
  logic           done_q;
  logic [n-1:0]   result_q;
  logic           lost_q;

  logic [n-1:0]   shift_d;
  logic           out_bit_d;
  logic [SHW-1:0] shamt_d;
  logic           accept_d;

  sr1 #(.n(n)) u_sr1 (
    .val_i  (data_q),
    .fill_i (fill_q),
    .val_o  (shift_d),
    .out_o  (out_bit_d)
  );

  assign shamt_d  = SHW'(clamp_shamt(32'(shamt), n));
  // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
  assign accept_d = start && ((state_q == IDLE) || (state_q == DONE));

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= CNT_ZERO;
      fill_q     <= 1'b0;
      lost_acc_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      lost_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Publish the finished operation one edge after reaching DONE; this
      // gives the shamt+1 latency and keeps every output registered.
      if (state_q == DONE) begin
        done_q   <= 1'b1;
        result_q <= data_q;
        lost_q   <= lost_acc_q;
      end
      if (accept_d) begin
        data_q     <= num;
        cnt_q      <= shamt_d;
        fill_q     <= arith & num[n-1];
        lost_acc_q <= 1'b0;
        if (shamt_d == CNT_ZERO) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
        end else begin
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          SHIFT: begin
            data_q     <= shift_d;
            lost_acc_q <= lost_acc_q | out_bit_d;
            cnt_q      <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= SHIFT;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          IDLE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign lost   = lost_q;

endmodule

// File: tb/tb_sr_iter.sv
// -----------------------------------------------------------------------------
// tb_sr_iter
//   Self-checking bench for sr_iter: directed cases plus random operations
//   compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sr_iter;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] num;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        lost;

  int total;
  int bad;

  sr_iter #(.n(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .num     (num),
    .shamt   (shamt),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .lost    (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] model_res(input logic [31:0] a, input int s, input logic ar);
    logic signed [31:0] sa;
    sa = a;
    if (ar) return 32'(sa >>> s);
    else    return a >> s;
  endfunction

  // Reference: any set bit among the s low bits is lost.
  function automatic logic model_lost(input logic [31:0] a, input int s);
    logic [63:0] mask;
    mask = (64'd1 << s) - 64'd1;
    return |(a & mask[31:0]);
  endfunction

  // Runs one operation; checks latency, busy cycles, result and lost.
  task automatic run_op(input logic [31:0] a, input int s, input logic ar, input string name);
    logic [31:0] er;
    logic        el;
    int          edges;
    int          busy_cnt;
    er = model_res(a, s, ar);
    el = model_lost(a, s);
    start = 1'b1; num = a; shamt = 5'(s); arith = ar;
    @(posedge clk); #1;
    start = 1'b0; num = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    edges = 0; busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    total++;
    if (edges !== s + 1) begin
      bad++; $display("FAIL %s latency: got %0d edges, want %0d", name, edges, s + 1);
    end
    total++;
    if (busy_cnt !== s) begin
      bad++; $display("FAIL %s busy_cycles: got %0d, want %0d", name, busy_cnt, s);
    end
    total++;
    if (result !== er) begin
      bad++; $display("FAIL %s result: got %h, want %h", name, result, er);
    end
    total++;
    if (lost !== el) begin
      bad++; $display("FAIL %s lost: got %b, want %b", name, lost, el);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
    end
  endtask

  task automatic check_idle_zero(input string name);
    total++;
    if ({busy, done, lost} !== 3'b000 || result !== 32'h0) begin
      bad++;
      $display("FAIL %s: got busy=%b done=%b lost=%b result=%h, want all 0",
               name, busy, done, lost, result);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; num = 32'h0; shamt = 5'd0; arith = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("after_reset_release");
  endtask

  task automatic test_directed();
    logic [31:0] held;
    run_op(32'h000000A0, 5, 1'b0, "t1_div32");
    held = result;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || result !== held) begin
      bad++; $display("FAIL t1_done_pulse_hold: got done=%b result=%h, want 0 / %h", done, result, held);
    end
    run_op(32'h80000001, 4, 1'b1, "t2_arith_neg");
    run_op(32'h12345678, 0, 1'b0, "t3_zero_shift");
    run_op(32'hFFFFFFFF, 31, 1'b0, "t4_max_logical");
    run_op(32'h00000040, 2, 1'b0, "t4_back_to_back");
    run_op(32'h80000000, 31, 1'b1, "max_arith_neg");
  endtask

  // A start pulse during SHIFT must be ignored.
  task automatic test_ignore_start();
    logic [31:0] a;
    int          edges;
    a = 32'hDEADBEEF;
    start = 1'b1; num = a; shamt = 5'd8; arith = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    repeat (2) begin @(posedge clk); #1; edges++; end
    start = 1'b1; num = 32'h0000FFFF; shamt = 5'd3; arith = 1'b1;
    @(posedge clk); #1; edges++;
    start = 1'b0;
    while (!done && edges < 100) begin @(posedge clk); #1; edges++; end
    total++;
    if (edges !== 9) begin
      bad++; $display("FAIL t5_latency: got %0d edges, want 9", edges);
    end
    total++;
    if (result !== (a >> 8) || lost !== 1'b1) begin
      bad++; $display("FAIL t5_result: got %h/%b, want %h/1", result, lost, a >> 8);
    end
  endtask

  // Reset mid-operation discards it; reset beats a simultaneous start.
  task automatic test_reset_midop();
    int seen;
    start = 1'b1; num = 32'hFFFF0000; shamt = 5'd10; arith = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("t6_reset_midop");
    reset_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done || busy) seen++; end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL t6_no_done: got %0d active cycles, want 0", seen);
    end
    reset_n = 1'b0; start = 1'b1; num = 32'h11111111; shamt = 5'd0;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (done || busy) seen++; end
    total++;
    if (seen !== 0 || result !== 32'h0) begin
      bad++; $display("FAIL reset_beats_start: got %0d active cycles result=%h, want 0 / 0", seen, result);
    end
    run_op(32'hC0000003, 10, 1'b1, "t6_fresh_op");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, int'($urandom_range(31, 0)), 1'($urandom), "random");
      if ($urandom_range(1, 0) == 1) begin
        repeat (int'($urandom_range(2, 0))) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
